// File: rtl/tsu_pkg.sv
// Shared types and helpers for the multi-channel TSU timestamp collector.
// Widths here are the defaults; the collector re-derives its record layout from its parameters.
package tsu_pkg;

  localparam int unsigned NChanDef    = 4;
  localparam int unsigned CntPrecBits = 64;
  localparam int unsigned RatPrecBits = 32;
  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned ChBitsDef   = 2;
  // Upper bound on channel count supported by rr_next.
  localparam int unsigned MaxChan     = 32;

  typedef struct packed {
    logic [ChBitsDef-1:0]   chan;
    logic [CntPrecBits-1:0] cnt;
    logic [RatPrecBits-1:0] phase;
  } ts_rec_t;

  // First requester found searching upward from (last + 1) mod n; returns last if none request.
  function automatic int unsigned rr_next(input logic [MaxChan-1:0] req,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned idx;
    rr_next = last;
    // Walk offsets from far to near so the nearest requester is written last.
    for (int unsigned off = MaxChan; off >= 1; off--) begin
      if (off <= n) begin
        idx = (last + off) % n;
        if (req[idx[4:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/tsu_stamp_fifo.sv
// Per-channel synchronous record FIFO; pointers carry an extra wrap bit to tell full from empty.
module tsu_stamp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted when the same cycle frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tsu_stamp_collector.sv
// Tags per-channel TSU phase results with the 1588 cycle count and channel id, queues them per
// channel and streams them out through one round-robin arbitrated valid/ready register stage.
module tsu_stamp_collector
  import tsu_pkg::*;
#(
  parameter int unsigned N_CHAN        = NChanDef,
  parameter int unsigned CNT_PREC_BITS = CntPrecBits,
  parameter int unsigned RAT_PREC_BITS = RatPrecBits,
  parameter int unsigned FIFO_DEPTH    = FifoDepth,
  localparam int unsigned CH_BITS      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_cnt_load,
  input  logic [CNT_PREC_BITS-1:0]               i_cnt_load_val,
  input  logic [N_CHAN-1:0]                      i_chan_en,
  input  logic [N_CHAN-1:0][RAT_PREC_BITS-1:0]   i_phase,
  input  logic [N_CHAN-1:0]                      i_phase_v,
  output logic                                   o_ts_v,
  input  logic                                   i_ts_rdy,
  output logic [CH_BITS-1:0]                     o_ts_chan,
  output logic [CNT_PREC_BITS-1:0]               o_ts_cnt,
  output logic [RAT_PREC_BITS-1:0]               o_ts_phase,
  output logic [N_CHAN-1:0]                      o_ovf,
  input  logic [N_CHAN-1:0]                      i_ovf_clr,
  output logic [CNT_PREC_BITS-1:0]               o_cnt
);

  localparam int unsigned RecW = CH_BITS + CNT_PREC_BITS + RAT_PREC_BITS;

  typedef struct packed {
    logic [CH_BITS-1:0]       chan;
    logic [CNT_PREC_BITS-1:0] cnt;
    logic [RAT_PREC_BITS-1:0] phase;
  } rec_t;

  logic [CNT_PREC_BITS-1:0]     cnt_q;
  logic [N_CHAN-1:0]            ovf_q;
  logic                         ts_v_q;
  rec_t                         ts_rec_q;
  logic [CH_BITS-1:0]           last_q;

  logic [N_CHAN-1:0]            capture, push, pop, ovf_set;
  logic [N_CHAN-1:0]            fifo_full, fifo_empty;
  logic [N_CHAN-1:0][RecW-1:0]  fifo_rdata;
  logic                         load;
  logic [CH_BITS-1:0]           grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_cnt_load) begin
      cnt_q <= i_cnt_load_val;
    end else begin
      cnt_q <= cnt_q + CNT_PREC_BITS'(1);
    end
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    rec_t wrec;
    assign wrec = '{chan: CH_BITS'(c), cnt: cnt_q, phase: i_phase[c]};

    tsu_stamp_fifo #(
      .WIDTH (RecW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (wrec),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  always_comb begin
    capture = i_phase_v & i_chan_en;
    load    = (!ts_v_q || i_ts_rdy) && (|(~fifo_empty));
    grant   = CH_BITS'(rr_next(MaxChan'(~fifo_empty), 32'(last_q), N_CHAN));
    pop     = '0;
    if (load) pop[grant] = 1'b1;
    push    = capture & (~fifo_full | pop);
    ovf_set = capture & fifo_full & ~pop;
  end

  // last_q resets to the top channel so the first search starts at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q    <= '0;
      ts_v_q   <= 1'b0;
      ts_rec_q <= '0;
      last_q   <= CH_BITS'(N_CHAN - 1);
    end else begin
      ovf_q <= (ovf_q & ~i_ovf_clr) | ovf_set;
      if (load) begin
        ts_v_q   <= 1'b1;
        ts_rec_q <= rec_t'(fifo_rdata[grant]);
        last_q   <= grant;
      end else if (i_ts_rdy) begin
        ts_v_q <= 1'b0;
      end
    end
  end

  assign o_ts_v     = ts_v_q;
  assign o_ts_chan  = ts_rec_q.chan;
  assign o_ts_cnt   = ts_rec_q.cnt;
  assign o_ts_phase = ts_rec_q.phase;
  assign o_ovf      = ovf_q;
  assign o_cnt      = cnt_q;

endmodule
